// File: rtl/params.sv
// Shared element-format and shape types for the systolic-array load/store path.
package params;
  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } type_t;

  typedef logic [1:0] rc_t;
endpackage

// File: rtl/d_writeback_pack_if.sv
// Write-beat channel between the write-back packer and the downstream writer.
interface d_writeback_pack_if;
  logic         wvalid;
  logic         wready;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast;
  logic [5:0]   burst_num;

  modport master (output wvalid, wdata, wstrb, wlast, burst_num, input wready);
  modport slave  (input wvalid, wdata, wstrb, wlast, burst_num, output wready);
endinterface

// File: rtl/d_writeback_pack.sv
// Drains 8x8x32b result tiles through a 2-entry ping-pong buffer and packs each
// array row into one 256-bit write beat in the job's element format.
module d_writeback_pack #(
  parameter int unsigned TILES = 4,
  parameter int unsigned ROWS  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  params::type_t           data_type,
  input  params::rc_t             rc,
  input  logic                    tile_valid,
  output logic                    tile_ready,
  input  logic [7:0][7:0][31:0]   tile_data,
  d_writeback_pack_if.master      w,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned TCNT_W = $clog2(TILES + 1);
  localparam logic [5:0]  LAST_BEAT = 6'(TILES * ROWS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0]  strb;
    logic [255:0] data;
  } beat_t;

  state_t                   state_q, state_d;
  params::type_t            dtype_q, dtype_d;
  logic [1:0][7:0][7:0][31:0] buf_q, buf_d;
  logic                     head_q, head_d, tail_q, tail_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [TCNT_W-1:0]        tacc_q, tacc_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [5:0]               burst_q, burst_d;
  logic                     wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic [255:0]             wdata_q, wdata_d;
  logic [31:0]              wstrb_q, wstrb_d;
  logic                     tile_ready_q, tile_ready_d;
  logic                     busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                     fire_w, fire_t, pop;
  logic [7:0][31:0]         src_row;
  beat_t                    beat;

  // Clamp a signed 32-bit accumulator into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic [31:0] e);
    if (!e[31] && (|e[30:15]))     return 16'h7FFF;
    else if (e[31] && !(&e[30:15])) return 16'h8000;
    else                            return e[15:0];
  endfunction

  function automatic beat_t pack_row(input params::type_t dt, input logic [7:0][31:0] r);
    beat_t b;
    b.data = '0;
    b.strb = 32'h0000_FFFF;
    for (int i = 0; i < 8; i++) begin
      case (dt)
        params::FP16: b.data[16*i +: 16] = r[i][15:0];
        params::INT4: b.data[16*i +: 16] = sat16(r[i]);
        default: begin
          b.data[32*i +: 32] = r[i];
          b.strb             = 32'hFFFF_FFFF;
        end
      endcase
    end
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    dtype_d = dtype_q;
    buf_d   = buf_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    tacc_d  = tacc_q;
    row_d   = row_q;
    burst_d = burst_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fire_w  = wvalid_q && w.wready;
    fire_t  = tile_valid && tile_ready_q;
    pop     = fire_w && (row_q == ROW_W'(ROWS - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          if (rc == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            dtype_d = data_type;
            head_d  = 1'b0;
            tail_d  = 1'b0;
            cnt_d   = '0;
            tacc_d  = '0;
            row_d   = '0;
            burst_d = '0;
          end
        end
      end
      RUN: begin
        if (fire_t) begin
          buf_d[tail_q] = tile_data;
          tail_d        = ~tail_q;
          tacc_d        = tacc_q + TCNT_W'(1);
        end
        if (fire_w) begin
          row_d   = row_q + ROW_W'(1);
          burst_d = burst_q + 6'd1;
        end
        if (pop) head_d = ~head_q;
        cnt_d = cnt_q + {1'b0, fire_t} - {1'b0, pop};
        if (fire_w && wlast_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          head_d  = 1'b0;
          tail_d  = 1'b0;
          cnt_d   = '0;
          tacc_d  = '0;
          row_d   = '0;
          burst_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A tile landing this cycle in the slot that becomes head bypasses the buffer.
    src_row = (fire_t && (tail_q == head_d)) ? tile_data[row_d] : buf_q[head_d][row_d];
    beat    = pack_row(dtype_q, src_row);

    wvalid_d     = (state_d == RUN) && (cnt_d != 2'd0);
    wdata_d      = wvalid_d ? beat.data : '0;
    wstrb_d      = wvalid_d ? beat.strb : '0;
    wlast_d      = wvalid_d && (burst_d == LAST_BEAT);
    tile_ready_d = (state_d == RUN) && (cnt_d < 2'd2) && (tacc_d < TCNT_W'(TILES));
    busy_d       = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dtype_q      <= params::FP32;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      cnt_q        <= '0;
      tacc_q       <= '0;
      row_q        <= '0;
      burst_q      <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wlast_q      <= 1'b0;
      tile_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dtype_q      <= dtype_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      tacc_q       <= tacc_d;
      row_q        <= row_d;
      burst_q      <= burst_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wlast_q      <= wlast_d;
      tile_ready_q <= tile_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Tile storage carries no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign w.wvalid    = wvalid_q;
  assign w.wdata     = wdata_q;
  assign w.wstrb     = wstrb_q;
  assign w.wlast     = wlast_q;
  assign w.burst_num = burst_q;
  assign tile_ready  = tile_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
endmodule

// File: tb/tb_d_writeback_pack.sv
// Self-checking bench for d_writeback_pack: vector table of packing cases plus
// scoreboarded jobs under backpressure, illegal shape, start-in-run and mid-job reset.
module tb_d_writeback_pack;
  import params::*;

  logic                  clk = 1'b0;
  logic                  rst, start, tile_valid, tile_ready, busy, done, err;
  type_t                 data_type;
  rc_t                   rc;
  logic [7:0][7:0][31:0] tile_data;

  d_writeback_pack_if wif();

  d_writeback_pack dut (
    .clk(clk), .rst(rst), .start(start), .data_type(data_type), .rc(rc),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
    .w(wif), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic         l;
    logic [5:0]   b;
  } beat_t;

  typedef struct {
    type_t       dt;
    logic [31:0] e;
    logic [31:0] lane;
    logic [31:0] strb;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  beat_t  q[$];
  int     wr_mode = 0;
  int     cyc = 0;
  logic   mon_en = 1'b0;
  logic   abort = 1'b0;
  logic   bp_check = 1'b0;
  logic   use_const = 1'b0;
  logic [255:0] c_data;
  logic [31:0]  c_strb;
  type_t  job_dt = FP32;
  int     beats_seen = 0;
  int     dones_seen = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_sat(input logic [31:0] e);
    int s;
    s = int'($signed(e));
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return e[15:0];
  endfunction

  function automatic logic [255:0] m_data(input type_t dt, input logic [7:0][31:0] r);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (dt == FP32 || dt == INT8) v[32*i +: 32] = r[i];
      else if (dt == FP16)          v[16*i +: 16] = r[i][15:0];
      else                          v[16*i +: 16] = m_sat(r[i]);
    end
    return v;
  endfunction

  function automatic logic [31:0] m_strb(input type_t dt);
    return (dt == FP16 || dt == INT4) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Downstream ready pattern: always, 1-0-0 repeating, or random.
  initial begin
    wif.wready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (wr_mode)
        0:       wif.wready = 1'b1;
        1:       wif.wready = (cyc % 3 == 0);
        default: wif.wready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Beat monitor: scoreboard pop, stall stability, done timing.
  logic  p_stall = 1'b0;
  logic  exp_done = 1'b0;
  beat_t p_beat, cur, e;
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      p_stall  = 1'b0;
      exp_done = 1'b0;
    end else begin
      chk("done_pulse", 320'(done), 320'(exp_done));
      exp_done = 1'b0;
      if (wif.wvalid) begin
        cur = {wif.wdata, wif.wstrb, wif.wlast, wif.burst_num};
        if (p_stall) chk("stall_hold", 320'(cur), 320'(p_beat));
        if (wif.wready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got burst %0d expected none", wif.burst_num);
          end else begin
            e = q.pop_front();
            chk("wdata", 320'(wif.wdata), 320'(e.d));
            chk("wstrb", 320'(wif.wstrb), 320'(e.s));
            chk("wlast", 320'(wif.wlast), 320'(e.l));
            chk("burst_num", 320'(wif.burst_num), 320'(e.b));
          end
          beats_seen++;
          if (wif.wlast) exp_done = 1'b1;
        end
        p_stall = !wif.wready;
        p_beat  = cur;
      end else begin
        p_stall = 1'b0;
      end
      if (done) dones_seen++;
    end
  end

  task automatic send_tiles(input int mode, input logic [31:0] val);
    logic [7:0][7:0][31:0] td;
    beat_t b;
    logic  acc;
    int    n;
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          td[r][c] = (mode == 0) ? 32'(r * 8 + c) : (mode == 1) ? val : $urandom;
      tile_data  = td;
      tile_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && !abort) begin
        @(negedge clk);
        if (abort) break;
        if (tile_ready) begin
          acc = 1'b1;
          for (int r = 0; r < 8; r++) begin
            b.d = use_const ? c_data : m_data(job_dt, td[r]);
            b.s = use_const ? c_strb : m_strb(job_dt);
            b.b = 6'(t * 8 + r);
            b.l = (t * 8 + r == 31);
            q.push_back(b);
          end
        end
        @(posedge clk);
        #1;
        n++;
        if (n > 2000) begin
          checks++;
          errors++;
          $display("FAIL tile_accept_timeout: got no tile_ready expected tile %0d accepted", t);
          break;
        end
      end
      if (acc && bp_check && t == 1) begin
        @(negedge clk);
        chk("tile_ready_full", 320'(tile_ready), 320'(0));
        @(posedge clk);
        #1;
      end
      if (abort || !acc) break;
    end
    tile_valid = 1'b0;
  endtask

  task automatic side_proc(input int extra);
    int n;
    if (extra == 1) begin
      repeat (6) @(posedge clk);
      #1;
      data_type = INT4;
      rc        = 2'b11;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("err_in_run", 320'(err), 320'(0));
      chk("busy_in_run", 320'(busy), 320'(1));
    end else if (extra == 2) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(wif.wvalid && wif.burst_num == 6'd13) && n < 2000);
      chk("reach_burst13", 320'(wif.burst_num), 320'(13));
      mon_en = 1'b0;
      abort  = 1'b1;
      rst    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", 320'({wif.wvalid, wif.wdata, wif.wstrb, wif.wlast, wif.burst_num,
                              busy, done, err, tile_ready}), 320'(0));
      rst = 1'b0;
      q.delete();
    end
  endtask

  task automatic run_job(input type_t dt, input rc_t r, input int mode, input logic [31:0] val,
                         input int wm, input int extra);
    int base, beats0, n;
    wr_mode   = wm;
    job_dt    = dt;
    data_type = dt;
    rc        = r;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    base   = dones_seen;
    beats0 = beats_seen;
    fork
      send_tiles(mode, val);
      side_proc(extra);
    join
    if (extra == 2) begin
      repeat (3) @(posedge clk);
      #1;
      abort  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 320'({busy, done, wif.wvalid}), 320'(0));
    end else begin
      n = 0;
      while (dones_seen == base && n < 3000) begin
        @(posedge clk);
        n++;
      end
      chk("job_done", 320'(dones_seen - base), 320'(1));
      chk("beat_count", 320'(beats_seen - beats0), 320'(32));
      chk("queue_empty", 320'(q.size()), 320'(0));
      @(negedge clk);
      chk("busy_after", 320'(busy), 320'(0));
    end
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    logic [31:0] ln;
    vt[0] = '{FP32, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF};
    vt[1] = '{INT8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    vt[2] = '{FP16, 32'hABCD_1234, 32'h0000_1234, 32'h0000_FFFF};
    vt[3] = '{INT4, 32'd100000,    32'h0000_7FFF, 32'h0000_FFFF};
    vt[4] = '{INT4, 32'hFFFE_7960, 32'h0000_8000, 32'h0000_FFFF};
    vt[5] = '{INT4, 32'hFFFF_FFFB, 32'h0000_FFFB, 32'h0000_FFFF};
    vt[6] = '{INT4, 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_FFFF};
    vt[7] = '{INT4, 32'h0000_8000, 32'h0000_7FFF, 32'h0000_FFFF};
    vt[8] = '{INT4, 32'hFFFF_8000, 32'h0000_8000, 32'h0000_FFFF};
    vt[9] = '{INT4, 32'hFFFF_7FFF, 32'h0000_8000, 32'h0000_FFFF};

    rst        = 1'b1;
    start      = 1'b0;
    data_type  = FP32;
    rc         = 2'b00;
    tile_valid = 1'b0;
    tile_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 320'({wif.wvalid, wif.wdata, wif.wstrb, wif.wlast, wif.burst_num,
                              busy, done, err, tile_ready}), 320'(0));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    run_job(FP32, 2'b00, 0, 32'h0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      ln     = vt[i].lane;
      c_data = (vt[i].strb == 32'hFFFF_FFFF) ? {8{ln}} : {128'b0, {8{ln[15:0]}}};
      c_strb = vt[i].strb;
      use_const = 1'b1;
      run_job(vt[i].dt, rc_t'(i % 3), 1, vt[i].e, i % 3, 0);
      use_const = 1'b0;
    end

    bp_check = 1'b1;
    run_job(FP32, 2'b01, 2, 32'h0, 1, 0);
    bp_check = 1'b0;
    run_job(INT4, 2'b10, 2, 32'h0, 2, 0);

    @(posedge clk);
    #1;
    rc    = 2'b11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", 320'({err, busy}), 320'(2'b10));
    @(negedge clk);
    chk("err_clear", 320'({err, busy}), 320'(2'b00));

    run_job(FP16, 2'b10, 2, 32'h0, 2, 1);
    run_job(FP32, 2'b00, 0, 32'h0, 0, 2);
    run_job(INT8, 2'b01, 0, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
